// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use and flush control.
// Define ID_EX_FORWARDING_EN to enable the EX/MEM bypass network.
module id_ex_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic [WORD_SIZE-1:0] id_immediate,
    input  logic [6:0]           id_opcode,
    input  logic [6:0]           id_funct7,
    input  logic [2:0]           id_funct3,
    input  logic [REG_BITS-1:0]  id_rs1,
    input  logic [REG_BITS-1:0]  id_rs2,
    input  logic [REG_BITS-1:0]  id_rd,
    input  logic [WORD_SIZE-1:0] id_rs1_data,
    input  logic [WORD_SIZE-1:0] id_rs2_data,
    input  logic [WORD_SIZE-1:0] ex_result,
    input  logic                 branch_taken,
    input  logic                 ex_stall,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic [REG_BITS-1:0]  mem_rd,
    input  logic [WORD_SIZE-1:0] mem_result,
    output logic                 ex_valid,
    output logic [WORD_SIZE-1:0] ex_pc,
    output logic [WORD_SIZE-1:0] ex_immediate,
    output logic [WORD_SIZE-1:0] ex_aluIn1,
    output logic [WORD_SIZE-1:0] ex_aluIn2,
    output logic [6:0]           ex_opcode,
    output logic [6:0]           ex_funct7,
    output logic [2:0]           ex_funct3,
    output logic [REG_BITS-1:0]  ex_rd,
    output logic                 ex_reg_write
);

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] immediate;
        logic [WORD_SIZE-1:0] alu_in1;
        logic [WORD_SIZE-1:0] alu_in2;
        logic [6:0]           opcode;
        logic [6:0]           funct7;
        logic [2:0]           funct3;
        logic [REG_BITS-1:0]  rd;
    } ex_bundle_t;

    ex_bundle_t           ex_q;
    ex_bundle_t           ex_d;
    logic                 ex_hit1;
    logic                 ex_hit2;
    logic                 mem_hit1;
    logic                 mem_hit2;
    logic                 hazard;
    logic                 flush;
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] op2;

    function automatic logic src_match(
        input logic                v,
        input logic                w,
        input logic [REG_BITS-1:0] rd,
        input logic [REG_BITS-1:0] rs
    );
        return v && w && (rs != '0) && (rd == rs);
    endfunction

    assign ex_hit1  = src_match(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rs1);
    assign ex_hit2  = src_match(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rs2);
    assign mem_hit1 = src_match(mem_valid, mem_reg_write, mem_rd, id_rs1);
    assign mem_hit2 = src_match(mem_valid, mem_reg_write, mem_rd, id_rs2);

    assign flush = ex_q.valid && branch_taken && !ex_stall;

`ifdef ID_EX_FORWARDING_EN
    logic ex_load;

    assign ex_load = (ex_q.opcode == OPCODE_LOAD);
    // A load's data only exists once it reaches MEM.
    assign hazard  = id_valid && ex_load && (ex_hit1 || ex_hit2);

    always_comb begin
        op1 = id_rs1_data;
        op2 = id_rs2_data;
        if (ex_hit1 && !ex_load) begin
            op1 = ex_result;
        end else if (mem_hit1) begin
            op1 = mem_result;
        end
        if (ex_hit2 && !ex_load) begin
            op2 = ex_result;
        end else if (mem_hit2) begin
            op2 = mem_result;
        end
    end
`else
    logic fwd_unused;

    // Without bypass, wait until no in-flight writer remains.
    assign hazard = id_valid &&
                    (ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2);
    assign op1 = id_rs1_data;
    assign op2 = id_rs2_data;
    assign fwd_unused = ^{ex_result, mem_result};
`endif

    assign id_ready = !reset && !ex_stall && !hazard;

    always_comb begin
        ex_d = '0;
        if (id_ready && id_valid && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = (id_opcode != OPCODE_STORE) &&
                             (id_opcode != OPCODE_BRANCH);
            ex_d.pc        = id_pc;
            ex_d.immediate = id_immediate;
            ex_d.alu_in1   = op1;
            ex_d.alu_in2   = op2;
            ex_d.opcode    = id_opcode;
            ex_d.funct7    = id_funct7;
            ex_d.funct3    = id_funct3;
            ex_d.rd        = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (!ex_stall) begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_pc        = ex_q.pc;
    assign ex_immediate = ex_q.immediate;
    assign ex_aluIn1    = ex_q.alu_in1;
    assign ex_aluIn2    = ex_q.alu_in2;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct7    = ex_q.funct7;
    assign ex_funct3    = ex_q.funct3;
    assign ex_rd        = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a behavioural pipeline model.
// Directed cases follow the ID_EX_FORWARDING_EN build setting.
module tb_id_ex_stage;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JUMP   = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_immediate;
    logic [6:0]  id_opcode;
    logic [6:0]  id_funct7;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] ex_result;
    logic        branch_taken;
    logic        ex_stall;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_immediate;
    logic [31:0] ex_aluIn1;
    logic [31:0] ex_aluIn2;
    logic [6:0]  ex_opcode;
    logic [6:0]  ex_funct7;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_immediate(id_immediate),
        .id_opcode(id_opcode), .id_funct7(id_funct7),
        .id_funct3(id_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .ex_result(ex_result), .branch_taken(branch_taken),
        .ex_stall(ex_stall),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_immediate(ex_immediate),
        .ex_aluIn1(ex_aluIn1), .ex_aluIn2(ex_aluIn2),
        .ex_opcode(ex_opcode), .ex_funct7(ex_funct7),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chkw(input string n, input logic [31:0] a,
                        input logic [31:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h, expected %h", n, a, e);
    endtask

    task automatic chkb(input string n, input logic a, input logic e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %b, expected %b", n, a, e);
    endtask

    // What the EX register should hold, kept as plain variables.
    logic        m_valid = 1'b0;
    logic        m_rw    = 1'b0;
    logic [31:0] m_pc, m_imm, m_in1, m_in2;
    logic [6:0]  m_op = 7'd0;
    logic [6:0]  m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd = 5'd0;
    bit          started = 1'b0;

    function automatic logic hits(input logic [4:0] rs, input logic v,
                                  input logic w, input logic [4:0] rd);
        return v && w && rs != 5'd0 && rs == rd;
    endfunction

    function automatic logic exp_hazard();
        logic e, m;
        e = hits(id_rs1, m_valid, m_rw, m_rd) ||
            hits(id_rs2, m_valid, m_rw, m_rd);
        m = hits(id_rs1, mem_valid, mem_reg_write, mem_rd) ||
            hits(id_rs2, mem_valid, mem_reg_write, mem_rd);
        if (FWD) return id_valid && e && m_op == LOAD;
        return id_valid && (e || m);
    endfunction

    function automatic logic exp_ready();
        return !reset && !ex_stall && !exp_hazard();
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs,
                                            input logic [31:0] rf);
        if (FWD && hits(rs, m_valid, m_rw, m_rd)) return ex_result;
        if (FWD && hits(rs, mem_valid, mem_reg_write, mem_rd))
            return mem_result;
        return rf;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b0; m_rw = 1'b0; m_pc = '0; m_imm = '0;
            m_in1 = '0; m_in2 = '0; m_op = '0; m_f7 = '0;
            m_f3 = '0; m_rd = '0;
        end else if (!ex_stall) begin
            if (!(m_valid && branch_taken) && exp_ready() && id_valid) begin
                m_in1   = operand(id_rs1, id_rs1_data);
                m_in2   = operand(id_rs2, id_rs2_data);
                m_valid = 1'b1;
                m_rw    = id_opcode != STORE && id_opcode != BRANCH;
                m_pc    = id_pc;
                m_imm   = id_immediate;
                m_op    = id_opcode;
                m_f7    = id_funct7;
                m_f3    = id_funct3;
                m_rd    = id_rd;
            end else begin
                m_valid = 1'b0;
                m_rw    = 1'b0;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chkb("id_ready", id_ready, exp_ready());
            chkb("ex_valid", ex_valid, m_valid);
            chkb("ex_reg_write", ex_reg_write, m_rw);
            if (m_valid) begin
                chkw("ex_pc", ex_pc, m_pc);
                chkw("ex_immediate", ex_immediate, m_imm);
                chkw("ex_aluIn1", ex_aluIn1, m_in1);
                chkw("ex_aluIn2", ex_aluIn2, m_in2);
                chkw("ex_opcode", 32'(ex_opcode), 32'(m_op));
                chkw("ex_funct7", 32'(ex_funct7), 32'(m_f7));
                chkw("ex_funct3", 32'(ex_funct3), 32'(m_f3));
                chkw("ex_rd", 32'(ex_rd), 32'(m_rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = '0; id_immediate = '0; id_opcode = '0;
        id_funct7 = '0; id_funct3 = '0; id_rs1 = '0; id_rs2 = '0;
        id_rd = '0; id_rs1_data = '0; id_rs2_data = '0;
        ex_result = '0; branch_taken = 0; ex_stall = 0;
        mem_valid = 0; mem_reg_write = 0; mem_rd = '0; mem_result = '0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pc);
        id_valid = 1; id_opcode = op; id_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2;
        id_pc = pc; id_immediate = pc + 32'd4;
        id_funct7 = 7'h20; id_funct3 = 3'd5;
    endtask

    logic [6:0] ops [6];

    initial begin
        ops = '{LOAD, STORE, BRANCH, JUMP, OP, OPIMM};

        reset = 1;
        clear_inputs();
        issue(OP, 5'd5, 5'd1, 5'd2, 32'h11, 32'h22, 32'h10);
        step();
        step();
        chkb("rst_valid", ex_valid, 1'b0);
        chkb("rst_rw", ex_reg_write, 1'b0);
        chkw("rst_pc", ex_pc, 32'h0);
        chkw("rst_in1", ex_aluIn1, 32'h0);
        chkw("rst_in2", ex_aluIn2, 32'h0);
        chkw("rst_rd", 32'(ex_rd), 32'h0);
        chkb("rst_ready", id_ready, 1'b0);
        reset = 0;
        clear_inputs();
        #1;
        chkb("ready_after_rst", id_ready, 1'b1);

        // add x5 then dependent sub x6,x5,x1
        issue(OP, 5'd5, 5'd1, 5'd2, 32'h11, 32'h22, 32'h100);
        step();
        ex_result = 32'd30;
        issue(OP, 5'd6, 5'd5, 5'd1, 32'h0, 32'h7, 32'h104);
        #1;
`ifdef ID_EX_FORWARDING_EN
        chkb("exfwd_ready", id_ready, 1'b1);
        step();
        chkb("exfwd_valid", ex_valid, 1'b1);
        chkw("exfwd_in1", ex_aluIn1, 32'd30);
`else
        chkb("exdep_ready0", id_ready, 1'b0);
        step();
        chkb("exdep_bubble0", ex_valid, 1'b0);
        mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd5;
        mem_result = 32'd30; ex_result = 32'd0;
        #1;
        chkb("exdep_ready1", id_ready, 1'b0);
        step();
        chkb("exdep_bubble1", ex_valid, 1'b0);
        mem_valid = 0; mem_reg_write = 0;
        #1;
        chkb("exdep_ready2", id_ready, 1'b1);
        step();
        chkb("exdep_valid", ex_valid, 1'b1);
        chkw("exdep_in1", ex_aluIn1, 32'h0);
`endif

        clear_inputs();
        step();
        mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd7;
        mem_result = 32'h55;
        issue(OP, 5'd8, 5'd0, 5'd7, 32'h0, 32'h99, 32'h200);
`ifdef ID_EX_FORWARDING_EN
        step();
        chkw("memfwd_in2", ex_aluIn2, 32'h55);
`else
        #1;
        chkb("memdep_ready", id_ready, 1'b0);
        step();
        mem_valid = 0; mem_reg_write = 0;
        step();
        chkw("memdep_in2", ex_aluIn2, 32'h99);
`endif

        mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd0;
        mem_result = 32'h55;
        issue(OP, 5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h204);
        step();
        chkb("x0_valid", ex_valid, 1'b1);
        chkw("x0_in2", ex_aluIn2, 32'h0);

        // lw x3 then a consumer of x3
        clear_inputs();
        issue(LOAD, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'h300);
        step();
        issue(OP, 5'd9, 5'd3, 5'd0, 32'hdead, 32'h0, 32'h304);
        #1;
        chkb("lu_ready", id_ready, 1'b0);
        step();
        chkb("lu_bubble", ex_valid, 1'b0);
        chkb("lu_bubble_rw", ex_reg_write, 1'b0);
        mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd3;
        mem_result = 32'h1234;
`ifdef ID_EX_FORWARDING_EN
        #1;
        chkb("lu_ready2", id_ready, 1'b1);
        step();
        chkb("lu_valid", ex_valid, 1'b1);
        chkw("lu_in1", ex_aluIn1, 32'h1234);
`else
        #1;
        chkb("lu_ready2", id_ready, 1'b0);
        step();
        mem_valid = 0; mem_reg_write = 0;
        step();
        chkw("lu_in1", ex_aluIn1, 32'hdead);
`endif

        clear_inputs();
        issue(BRANCH, 5'd0, 5'd1, 5'd2, 32'h5, 32'h5, 32'd400);
        step();
        branch_taken = 1;
        issue(OP, 5'd11, 5'd1, 5'd2, 32'h1, 32'h2, 32'd404);
        #1;
        chkb("br_ready", id_ready, 1'b1);
        step();
        chkb("br_flush_valid", ex_valid, 1'b0);
        chkb("br_flush_rw", ex_reg_write, 1'b0);

        clear_inputs();
        issue(BRANCH, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h600);
        step();
        ex_stall = 1; branch_taken = 1;
        mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd1;
        issue(OP, 5'd12, 5'd1, 5'd2, 32'h3, 32'h4, 32'h604);
        for (int i = 0; i < 3; i++) begin
            mem_result = $urandom;
            #1;
            chkb("stall_ready", id_ready, 1'b0);
            step();
            chkb("stall_valid", ex_valid, 1'b1);
            chkw("stall_pc", ex_pc, 32'h600);
        end
        ex_stall = 0;
        step();
        chkb("stall_then_flush", ex_valid, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            ex_stall     = ($urandom_range(0, 6) == 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_pc        = $urandom;
            id_immediate = $urandom;
            id_opcode    = ops[$urandom_range(0, 5)];
            id_funct7    = 7'($urandom);
            id_funct3    = 3'($urandom);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            ex_result    = $urandom;
            branch_taken = (m_valid && (m_op == BRANCH || m_op == JUMP))
                           ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_valid     = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_rd        = 5'($urandom_range(0, 3));
            mem_result    = $urandom;
            step();
        end

        reset = 0;
        clear_inputs();
        step();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-bypass stage between decode and the `alu` execute stage. It captures a decoded instruction, resolves RAW hazards by forwarding or bubble insertion, and presents `pc`, `opcode`, `funct7`, `funct3`, `aluIn1`, `aluIn2` and `immediate` to the ALU from flops. It also drops the younger instruction when the ALU resolves a taken branch or jump.

## Interface
- `WORD_SIZE`, 32, datapath width.
- `REG_BITS`, 5, register-index width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode presents an instruction.
- `id_ready`  out  1  EX accepts the instruction this cycle.
- `id_pc`, `id_immediate`  in  WORD_SIZE  decoded PC and sign-extended immediate.
- `id_opcode`  in  7, `id_funct7`  in  7, `id_funct3`  in  3  decoded fields.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_BITS  register indices.
- `id_rs1_data`, `id_rs2_data`  in  WORD_SIZE  register-file read data. Write-back writes before read in the same cycle.
- `ex_result`  in  WORD_SIZE  `aluOut` of the instruction currently held here.
- `branch_taken`  in  1  ALU `branchTaken` for the held instruction.
- `ex_stall`  in  1  downstream cannot accept; hold everything.
- `mem_valid`, `mem_reg_write`  in  1  MEM-stage instruction is valid and writes `mem_rd`.
- `mem_rd`  in  REG_BITS; `mem_result`  in  WORD_SIZE  MEM-stage destination and value.
- `ex_valid`  out  1  held instruction is valid.
- `ex_pc`, `ex_immediate`, `ex_aluIn1`, `ex_aluIn2`  out  WORD_SIZE  ALU inputs. `ex_aluIn2` carries forwarded rs2, which is also the store data.
- `ex_opcode`, `ex_funct7`  out  7; `ex_funct3`  out  3; `ex_rd`  out  REG_BITS.
- `ex_reg_write`  out  1  registered; 0 for `OPCODE_BRANCH`, `OPCODE_STORE` and invalid instructions.

## Operation
- Opcode constants come from the shared defines: `OPCODE_LOAD`, `OPCODE_STORE`, `OPCODE_BRANCH`, `OPCODE_JUMP`, and others.
- **Source match.** A source `rsN` matches stage S when all of the following hold: S is valid, S writes a register, S's rd equals `rsN`, and `rsN != 0`. Register x0 never matches.
- **Forwarding priority per operand:**
  - EX match with a non-load instruction -> `ex_result`.
  - Otherwise MEM match -> `mem_result`.
  - Otherwise register-file data.
- **Load-use hazard.** EX holds `OPCODE_LOAD` and an `id_valid` source matches its rd:
  - `id_ready=0` for exactly one cycle.
  - A bubble is captured: `ex_valid=0`, `ex_reg_write=0`.
  - The next cycle, the operand forwards from MEM.
- **Capture.** When `id_ready && id_valid`, all fields and forwarded operands are loaded and `ex_valid=1`. When `id_ready && !id_valid`, a bubble is loaded.
- **Flush.** `ex_valid && branch_taken && !ex_stall` -> a bubble is loaded next cycle regardless of ID. `id_ready=1`, so decode treats its instruction as consumed and discarded.
- **Per-cycle precedence:** reset > `ex_stall` (hold all flops) > flush > load-use bubble > capture.
- **Ready:** `id_ready = !reset && !ex_stall && !load_use_hazard`.

## Timing
- Reset value of every registered output is 0, including `ex_valid` and `ex_reg_write`. `id_ready=0` while `reset` is high.
- Latency is 1 cycle: an instruction accepted at edge N is on the `ex_*` outputs after edge N.
- `id_ready` and the forwarding muxes are combinational from the current-cycle inputs. Forwarded values are sampled at the capture edge only.
- During `ex_stall`, the captured operands are frozen. Forwarding is not re-evaluated while held.
- Reset asserted mid-stall or mid-hazard clears the stage the next edge. No held instruction survives.
- Back-to-back dependent ALU instructions issue with zero bubbles. A dependent instruction after a load issues with one bubble.

## Configuration
- `ID_EX_FORWARDING_EN` defined: bypass network as above.
- `ID_EX_FORWARDING_EN` undefined:
  - No bypass; operands always come from the register file.
  - Any EX or MEM source match, load or not, drops `id_ready` and inserts bubbles until no match remains (up to 2 cycles).
  - Flush and stall behaviour are unchanged.

## Test plan
- **Reset.** Reset for 2 cycles with `id_valid=1` -> all `ex_*`=0, `id_ready=0`. One cycle after release -> `id_ready=1`.
- **EX forward.** `add x5` (`ex_result=30`) followed by `sub x6,x5,x1` with `id_rs1_data=0` -> next cycle `ex_aluIn1=30`, no bubble. Without the macro: two bubbles, then `ex_aluIn1` equals the RF value.
- **MEM forward and x0.** `mem_rd=7`, `mem_result=0x55`, `id_rs2=7` -> `ex_aluIn2=0x55`. With `mem_rd=0`, `id_rs2=0`, `id_rs2_data=0` -> `ex_aluIn2=0`.
- **Load-use.** `lw x3` in EX, next instruction uses x3 -> `id_ready=0` for 1 cycle, then `ex_valid=0` for one cycle. The following cycle, `ex_aluIn1=mem_result=0x1234`.
- **Branch flush.** `beq` with `pc=400`, `branch_taken=1`, `id_valid=1` -> next cycle `ex_valid=0`, `ex_reg_write=0`.
- **Stall.** `ex_stall=1` for 3 cycles with `branch_taken=1` and changing `mem_result` -> `ex_*` unchanged and `id_ready=0`. Flush takes effect the cycle after `ex_stall` drops.
